// File: rtl/cell_bist_pkg.sv
// Shared types and constants for the 2-input cell self-test controller.
package cell_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXH,
    S_RND,
    S_DRAIN,
    S_DONE
  } state_t;

  // Fibonacci taps at bits 7,5,4,3 of the 8-bit LFSR
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;
  localparam logic [15:0] CRC_POLY  = 16'h1021;

  // Truth tables indexed by {A,B}
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/cell_bist_lfsr.sv
// Left-shifting Fibonacci LFSR supplying pseudo-random A/B vectors.
module cell_bist_lfsr
  import cell_bist_pkg::*;
#(
  parameter int              W    = 8,
  parameter logic [W-1:0]    SEED = 8'hA5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_step,
  output logic [W-1:0] o_q
);

  localparam logic [W-1:0] TAPS = W'(LFSR_TAPS);

  logic [W-1:0] r_q;
  logic         w_fb;

  assign w_fb = ^(r_q & TAPS);
  assign o_q  = r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) r_q <= SEED;
    else if (i_step)     r_q <= {r_q[W-2:0], w_fb};
  end

endmodule

// File: rtl/cell_bist_ctrl.sv
// BIST controller for one 2-input combinational cell: drives exhaustive then
// LFSR vectors, checks Y against TRUTH and folds Y into a CRC-16 signature.
module cell_bist_ctrl
  import cell_bist_pkg::*;
#(
  parameter logic [3:0]        TRUTH     = TT_AND2,
  parameter int                NRAND     = 16,
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5,
  parameter int                ERR_W     = 4,
  parameter int                SIG_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_y_dut,
  output logic             o_a_out,
  output logic             o_b_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [SIG_W-1:0] o_sig
);

  localparam int IDX_W = $clog2((NRAND > 4) ? NRAND : 4) + 1;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_a, r_b, r_busy, r_done, r_pass, r_chk;
  logic [ERR_W-1:0]   r_err;
  logic [SIG_W-1:0]   r_sig;
  logic [LFSR_W-1:0]  w_lfsr;
  logic               w_load, w_step, w_mis;
  logic [SIG_W-1:0]   w_sig_nxt;

  assign w_load = (r_state == S_IDLE || r_state == S_DONE) && i_start;
  // Step whenever the current LFSR value is consumed as a vector
  assign w_step = (r_state == S_EXH && r_idx == IDX_W'(3)) ||
                  (r_state == S_RND && r_idx != IDX_W'(NRAND - 1));

  cell_bist_lfsr #(.W(LFSR_W), .SEED(LFSR_SEED)) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .i_step (w_step),
    .o_q    (w_lfsr)
  );

  // Y observed now belongs to the A/B pair currently held in r_a/r_b
  assign w_mis     = i_y_dut != TRUTH[{r_a, r_b}];
  assign w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0} ^
                     (r_sig[SIG_W-1] ? SIG_W'(CRC_POLY) : '0) ^
                     {{(SIG_W-1){1'b0}}, i_y_dut};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_chk   <= 1'b0;
      r_err   <= '0;
      r_sig   <= '0;
    end else begin
      if (r_chk) begin
        if (w_mis && r_err != '1) r_err <= r_err + 1'b1;
        r_sig <= w_sig_nxt;
      end
      case (r_state)
        S_IDLE, S_DONE: if (i_start) begin
          r_state    <= S_EXH;
          r_idx      <= '0;
          {r_a, r_b} <= 2'b00;
          r_busy     <= 1'b1;
          r_done     <= 1'b0;
          r_pass     <= 1'b0;
          r_chk      <= 1'b1;
          r_err      <= '0;
          r_sig      <= '0;
        end
        S_EXH: if (r_idx == IDX_W'(3)) begin
          r_state    <= S_RND;
          r_idx      <= '0;
          {r_a, r_b} <= w_lfsr[1:0];
        end else begin
          r_idx      <= r_idx + 1'b1;
          {r_a, r_b} <= r_idx[1:0] + 2'd1;
        end
        S_RND: if (r_idx == IDX_W'(NRAND - 1)) begin
          r_state    <= S_DRAIN;
          {r_a, r_b} <= 2'b00;
          r_chk      <= 1'b0;
        end else begin
          r_idx      <= r_idx + 1'b1;
          {r_a, r_b} <= w_lfsr[1:0];
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (r_err == '0);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_a_out   = r_a;
  assign o_b_out   = r_b;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_pass    = r_pass;
  assign o_err_cnt = r_err;
  assign o_sig     = r_sig;

endmodule
